// File: rtl/ahb_pkg.sv
// Shared AHB protocol types and helpers for the bus fabric.
// Bus-width parameters live with the global definitions, not here.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_BURST,
    ARB_LOCKED
  } arb_state_e;

  // Undefined-length INCR is arbitrated beat by beat, so it counts as 1.
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    case (b)
      HBURST_SINGLE, HBURST_INCR:  burst_len = 5'd1;
      HBURST_WRAP4,  HBURST_INCR4: burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8: burst_len = 5'd8;
      default:                     burst_len = 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// Signal bundle for the arbiter; benches reach it through VTSB_ARBITER_IF.
interface arbiter_if #(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input logic clk
);
  logic                  rst;
  logic [MASTER_NUM-1:0] req;
  logic [MASTER_NUM-1:0] lock;
  logic [1:0]            trans;
  logic [2:0]            burst;
  logic                  ready;
  logic [MASTER_NUM-1:0] grant;
  logic [MIDX_W-1:0]     master_addr;
  logic [MIDX_W-1:0]     master_data;
  logic                  master_lock;
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester above `last`, wrapping.
// `last` itself is scanned last, so a lone owner keeps the bus.
module rr_pick #(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MIDX_W-1:0]     last,
  output logic [MASTER_NUM-1:0] win,
  output logic                  valid
);
  logic [MIDX_W:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      idx = {1'b0, last} + (MIDX_W+1)'(i);
      if (idx >= (MIDX_W+1)'(MASTER_NUM)) idx = idx - (MIDX_W+1)'(MASTER_NUM);
      if (!valid && req[idx[MIDX_W-1:0]]) begin
        win[idx[MIDX_W-1:0]] = 1'b1;
        valid                = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot grant held across fixed bursts and locked
// sequences, plus registered address/data-phase owner indices.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_NUM-1:0] lock,
  input  logic [1:0]            trans,
  input  logic [2:0]            burst,
  input  logic                  ready,
  output logic [MASTER_NUM-1:0] grant,
  output logic [MIDX_W-1:0]     master_addr,
  output logic [MIDX_W-1:0]     master_data,
  output logic                  master_lock
);
  arb_state_e            state;
  logic [4:0]            remain;
  logic [MIDX_W-1:0]     gidx;
  logic [MASTER_NUM-1:0] win;
  logic                  win_vld;
  logic                  beat, last_beat, owner_lock, owner_on_bus, arb_pt;
  logic [4:0]            eff;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (grant[i]) gidx = MIDX_W'(i);
  end

  rr_pick #(.MASTER_NUM(MASTER_NUM), .MIDX_W(MIDX_W)) u_pick (
    .req   (req),
    .last  (gidx),
    .win   (win),
    .valid (win_vld)
  );

  // A NONSEQ beat counts against the length it is loading, so SINGLE is
  // its own last beat.
  assign beat       = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  assign eff        = (trans == HTRANS_NONSEQ) ? burst_len(burst) : remain;
  assign last_beat  = beat && (eff == 5'd1);
  assign owner_lock = lock[gidx];

  // Until the grantee reaches the address phase, trans still belongs to the
  // previous owner and must not end the new tenure.
  assign owner_on_bus = (master_addr == gidx);
  assign arb_pt = !owner_lock &&
                  ((state == ARB_PARK) ||
                   (owner_on_bus && ((trans == HTRANS_IDLE) || last_beat)));

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= MASTER_NUM'(1);
      master_addr <= '0;
      master_data <= '0;
      master_lock <= 1'b0;
      state       <= ARB_PARK;
      remain      <= '0;
    end else if (ready) begin
      master_addr <= gidx;
      master_data <= master_addr;
      master_lock <= owner_lock;
      if (beat) remain <= (eff == 5'd0) ? 5'd0 : eff - 5'd1;
      if (owner_lock) begin
        state <= ARB_LOCKED;
      end else if (arb_pt) begin
        if (win_vld) begin
          grant <= win;
          state <= ARB_BURST;
        end else begin
          grant <= MASTER_NUM'(1);
          state <= ARB_PARK;
        end
      end else if (state == ARB_LOCKED) begin
        state <= ARB_BURST;
      end
    end
  end
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with a per-cycle reference model.
module tb_ahb_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  arbiter_if #(.MASTER_NUM(N)) aif (.clk(clk));
  typedef virtual arbiter_if VTSB_ARBITER_IF;
  VTSB_ARBITER_IF vif;

  ahb_arbiter #(.MASTER_NUM(N)) dut (
    .clk         (clk),
    .rst         (aif.rst),
    .req         (aif.req),
    .lock        (aif.lock),
    .trans       (aif.trans),
    .burst       (aif.burst),
    .ready       (aif.ready),
    .grant       (aif.grant),
    .master_addr (aif.master_addr),
    .master_data (aif.master_data),
    .master_lock (aif.master_lock)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index, address/data owners, beats left, parked flag.
  int m_gnt = 0, m_addr = 0, m_data = 0, m_lock = 0, m_left = 0;
  bit m_park = 1'b1;

  always @(posedge clk) begin
    bit last, lk, arb, found;
    int nxt;
    if (aif.rst) begin
      m_gnt = 0; m_addr = 0; m_data = 0; m_lock = 0; m_left = 0; m_park = 1'b1;
    end else if (aif.ready) begin
      last = 1'b0;
      nxt  = 0;
      if (aif.trans == 2'b10)
        m_left = (aif.burst < 3'd2) ? 1 : (1 << (int'(aif.burst[2:1]) + 1));
      if (aif.trans[1]) begin
        last = (m_left == 1);
        if (m_left > 0) m_left--;
      end
      lk  = aif.lock[m_gnt];
      arb = !lk && (m_park || (m_addr == m_gnt && (aif.trans == 2'b00 || last)));
      m_data = m_addr;
      m_addr = m_gnt;
      m_lock = int'(lk);
      if (lk) m_park = 1'b0;
      else if (arb) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++)
          if (!found && aif.req[(m_gnt + k) % N]) begin
            nxt = (m_gnt + k) % N;
            found = 1'b1;
          end
        m_gnt  = found ? nxt : 0;
        m_park = !found;
      end
    end
  end

  always @(negedge clk) begin
    chk("grant",       int'(aif.grant),       1 << m_gnt);
    chk("master_addr", int'(aif.master_addr), m_addr);
    chk("master_data", int'(aif.master_data), m_data);
    chk("master_lock", int'(aif.master_lock), m_lock);
  end

  task automatic cyc(input logic [1:0] tr, input logic [2:0] bu = 3'b000,
                     input logic rdy = 1'b1);
    vif.trans = tr;
    vif.burst = bu;
    vif.ready = rdy;
    @(negedge clk);
  endtask

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101;

  int rr_exp [8] = '{2, 3, 0, 1, 2, 3, 0, 1};

  initial begin
    vif = aif;
    vif.rst = 1'b1; vif.req = '0; vif.lock = '0;
    vif.trans = IDLE; vif.burst = SINGLE; vif.ready = 1'b1;

    // reset then idle
    cyc(IDLE); cyc(IDLE);
    chk("rst_grant", int'(aif.grant), 1);
    chk("rst_addr",  int'(aif.master_addr), 0);
    chk("rst_data",  int'(aif.master_data), 0);
    chk("rst_lock",  int'(aif.master_lock), 0);
    vif.rst = 1'b0;
    repeat (3) cyc(IDLE);
    chk("idle_grant", int'(aif.grant), 1);

    // single request from master 2
    vif.req = 4'b0100;
    cyc(IDLE);
    chk("single_grant", int'(aif.grant), 4'b0100);
    cyc(IDLE);
    chk("single_addr", int'(aif.master_addr), 2);
    cyc(NSEQ, SINGLE);
    chk("single_data", int'(aif.master_data), 2);
    vif.req = '0;
    repeat (3) cyc(IDLE);

    // INCR4 by master 1 with BUSY and wait states, master 3 waiting
    vif.req = 4'b1010;
    cyc(IDLE);
    chk("incr4_grant", int'(aif.grant), 4'b0010);
    cyc(IDLE);
    cyc(NSEQ, INCR4);
    cyc(BUSY, INCR4);
    cyc(SEQ, INCR4, 1'b0);
    cyc(SEQ, INCR4);
    cyc(SEQ, INCR4);
    cyc(SEQ, INCR4, 1'b0);
    chk("incr4_hold", int'(aif.grant), 4'b0010);
    cyc(SEQ, INCR4);
    chk("incr4_handover", int'(aif.grant), 4'b1000);
    vif.req = 4'b1000;
    cyc(IDLE);
    vif.req = '0;
    cyc(NSEQ, SINGLE);
    repeat (2) cyc(IDLE);

    // round robin with everyone requesting
    vif.req = 4'b1111;
    cyc(IDLE);
    chk("rr_first", int'(aif.grant), 4'b0010);
    for (int i = 0; i < 8; i++) begin
      cyc(IDLE);
      cyc(NSEQ, SINGLE);
      chk($sformatf("rr_order%0d", i), int'(aif.grant), 1 << rr_exp[i]);
    end
    vif.req = '0;
    repeat (3) cyc(IDLE);

    // locked sequence by master 3
    vif.req = 4'b1000; vif.lock = 4'b1000;
    cyc(IDLE);
    vif.req = 4'b1111;
    cyc(IDLE);
    for (int i = 0; i < 3; i++) begin
      cyc(NSEQ, SINGLE);
      chk($sformatf("lock_grant%0d", i), int'(aif.grant), 4'b1000);
      chk($sformatf("lock_flag%0d", i),  int'(aif.master_lock), 1);
    end
    vif.lock = '0;
    cyc(IDLE);
    chk("unlock_grant", int'(aif.grant), 4'b0001);
    chk("unlock_flag",  int'(aif.master_lock), 0);
    vif.req = '0;
    repeat (3) cyc(IDLE);

    // reset during beat 5 of master 2's INCR8, with req dropped mid-burst
    vif.req = 4'b0100;
    cyc(IDLE);
    cyc(IDLE);
    cyc(NSEQ, INCR8);
    vif.req = '0;
    repeat (3) cyc(SEQ, INCR8);
    chk("incr8_hold", int'(aif.grant), 4'b0100);
    vif.rst = 1'b1;
    cyc(SEQ, INCR8);
    chk("midrst_grant", int'(aif.grant), 1);
    chk("midrst_addr",  int'(aif.master_addr), 0);
    chk("midrst_data",  int'(aif.master_data), 0);
    vif.rst = 1'b0;
    repeat (3) cyc(IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
